// File: rtl/pc_pkg.sv
// Shared definitions for the IF-stage next-PC controller and the fetch stage.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        DRAIN  = 2'b10,
        HALTED = 2'b11
    } pc_state_e;

    localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
    localparam logic [15:0] DEF_PC_INC    = 16'd2;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a branch redirect that arrived while instruction memory was busy.
module pc_redirect_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_i,
    input  logic [15:0] tgt_i,
    input  logic        clr_i,
    output logic        pend_v_o,
    output logic [15:0] pend_tgt_o
);

    logic        pend_v_q;
    logic [15:0] pend_tgt_q;

    // A newer redirect simply overwrites an older one; set wins over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v_q   <= 1'b0;
            pend_tgt_q <= 16'h0000;
        end else if (set_i) begin
            pend_v_q   <= 1'b1;
            pend_tgt_q <= tgt_i;
        end else if (clr_i) begin
            pend_v_q   <= 1'b0;
        end
    end

    assign pend_v_o   = pend_v_q;
    assign pend_tgt_o = pend_tgt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: drives D/WE/RE of the external PC register and sequences
// increment, branch redirect, stalls and the HLT drain-to-halt flow.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [15:0] PC_INC    = DEF_PC_INC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_q,
    input  logic        imem_busy,
    input  logic        hazard_stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        halt_dec,
    input  logic        halt_commit,
    input  logic        dbg_rd,
    output logic [15:0] pc_d,
    output logic        pc_we,
    output logic        pc_re1,
    output logic        pc_re2,
    output logic        fetch_valid,
    output logic        if_flush,
    output logic        halted
);

    pc_state_e   state_q, state_d;
    logic        pend_set, pend_clr;
    logic        pend_v;
    logic [15:0] pend_tgt;

    pc_redirect_buf u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .set_i      (pend_set),
        .tgt_i      (br_target),
        .clr_i      (pend_clr),
        .pend_v_o   (pend_v),
        .pend_tgt_o (pend_tgt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_we       = 1'b0;
        fetch_valid = 1'b0;
        if_flush    = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        case (state_q)
            BOOT: begin
                pc_we   = 1'b1;
                pc_d    = RESET_VEC;
                state_d = RUN;
            end
            RUN: begin
                // Memory busy must never see a PC write; a redirect is parked instead.
                if (imem_busy) begin
                    if (br_taken) begin
                        pend_set = 1'b1;
                        if_flush = 1'b1;
                    end
                end else if (br_taken) begin
                    pc_we    = 1'b1;
                    pc_d     = br_target;
                    if_flush = 1'b1;
                    pend_clr = 1'b1;
                end else if (pend_v) begin
                    pc_we    = 1'b1;
                    pc_d     = pend_tgt;
                    pend_clr = 1'b1;
                end else if (hazard_stall) begin
                    pc_we = 1'b0;
                end else if (halt_dec) begin
                    state_d = DRAIN;
                end else begin
                    pc_we       = 1'b1;
                    pc_d        = pc_q + PC_INC;
                    fetch_valid = 1'b1;
                end
            end
            DRAIN: begin
                // A taken branch here means the HLT was on the wrong path.
                if (halt_commit) begin
                    state_d = HALTED;
                end else if (br_taken) begin
                    state_d  = RUN;
                    if_flush = 1'b1;
                    if (imem_busy) begin
                        pend_set = 1'b1;
                    end else begin
                        pc_we    = 1'b1;
                        pc_d     = br_target;
                        pend_clr = 1'b1;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        if (!rst) begin
            pc_d        = RESET_VEC;
            pc_we       = 1'b0;
            fetch_valid = 1'b0;
            if_flush    = 1'b0;
        end
    end

    assign pc_re1 = rst;
    assign pc_re2 = dbg_rd;
    assign halted = rst && (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; models the external PC register so pc_q follows pc_d/pc_we.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_q;
    logic        imem_busy, hazard_stall, br_taken, halt_dec, halt_commit, dbg_rd;
    logic [15:0] br_target;
    logic [15:0] pc_d;
    logic        pc_we, pc_re1, pc_re2, fetch_valid, if_flush, halted;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .pc_q         (pc_q),
        .imem_busy    (imem_busy),
        .hazard_stall (hazard_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .halt_dec     (halt_dec),
        .halt_commit  (halt_commit),
        .dbg_rd       (dbg_rd),
        .pc_d         (pc_d),
        .pc_we        (pc_we),
        .pc_re1       (pc_re1),
        .pc_re2       (pc_re2),
        .fetch_valid  (fetch_valid),
        .if_flush     (if_flush),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // External PC register
    logic [15:0] pc_reg = 16'hDEAD;
    always @(posedge clk) begin
        if (pc_we) pc_reg <= pc_d;
    end
    assign pc_q = pc_reg;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then clear per-cycle strobes.
    task automatic step();
        @(posedge clk);
        #1;
        br_taken    = 1'b0;
        halt_dec    = 1'b0;
        halt_commit = 1'b0;
        hazard_stall = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0; imem_busy = 1'b0; hazard_stall = 1'b0; br_taken = 1'b0;
        br_target = 16'h0000; halt_dec = 1'b0; halt_commit = 1'b0; dbg_rd = 1'b1;
        #3;
        chk("rst_we", {15'd0, pc_we}, 16'd0);
        chk("rst_d", pc_d, 16'h0000);
        chk("rst_re1", {15'd0, pc_re1}, 16'd0);
        chk("rst_re2", {15'd0, pc_re2}, 16'd1);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_fv", {15'd0, fetch_valid}, 16'd0);
        step();
        rst = 1'b1; dbg_rd = 1'b0; settle();
        $display("boot: pc_d=%h pc_we=%b", pc_d, pc_we);
        chk("boot_we", {15'd0, pc_we}, 16'd1);
        chk("boot_d", pc_d, 16'h0000);
        chk("boot_fv", {15'd0, fetch_valid}, 16'd0);
        chk("boot_re1", {15'd0, pc_re1}, 16'd1);
        chk("re2_follow", {15'd0, pc_re2}, 16'd0);

        // Sequential increments
        step(); settle();
        $display("seq: pc_q=%h pc_d=%h fv=%b", pc_q, pc_d, fetch_valid);
        chk("seq1_d", pc_d, 16'h0002);
        chk("seq1_fv", {15'd0, fetch_valid}, 16'd1);
        step(); settle();
        chk("seq2_d", pc_d, 16'h0004);
        step(); settle();
        chk("seq3_d", pc_d, 16'h0006);
        chk("seq3_we", {15'd0, pc_we}, 16'd1);

        // Branch to 0x0010, then 0x0010 -> 0x0100
        step(); br_taken = 1'b1; br_target = 16'h0010; settle();
        chk("br0_d", pc_d, 16'h0010);
        step(); br_taken = 1'b1; br_target = 16'h0100; settle();
        $display("br: pc_q=%h pc_d=%h flush=%b", pc_q, pc_d, if_flush);
        chk("br_pcq", pc_q, 16'h0010);
        chk("br_d", pc_d, 16'h0100);
        chk("br_we", {15'd0, pc_we}, 16'd1);
        chk("br_flush", {15'd0, if_flush}, 16'd1);
        chk("br_fv", {15'd0, fetch_valid}, 16'd0);
        step(); settle();
        chk("br_next_d", pc_d, 16'h0102);

        // Busy window with two redirects; the later one wins
        step(); imem_busy = 1'b1; br_taken = 1'b1; br_target = 16'h0040; settle();
        $display("busy1: pc_we=%b flush=%b", pc_we, if_flush);
        chk("busy1_we", {15'd0, pc_we}, 16'd0);
        chk("busy1_flush", {15'd0, if_flush}, 16'd1);
        step(); imem_busy = 1'b1; br_taken = 1'b1; br_target = 16'h0080; settle();
        chk("busy2_we", {15'd0, pc_we}, 16'd0);
        step(); imem_busy = 1'b1; settle();
        chk("busy3_we", {15'd0, pc_we}, 16'd0);
        chk("busy3_fv", {15'd0, fetch_valid}, 16'd0);
        step(); imem_busy = 1'b0; settle();
        $display("pend: pc_d=%h pc_we=%b fv=%b", pc_d, pc_we, fetch_valid);
        chk("pend_d", pc_d, 16'h0080);
        chk("pend_we", {15'd0, pc_we}, 16'd1);
        chk("pend_fv", {15'd0, fetch_valid}, 16'd0);
        step(); settle();
        chk("pend_clr_d", pc_d, 16'h0082);
        chk("pend_clr_fv", {15'd0, fetch_valid}, 16'd1);

        // Hazard stall
        step(); hazard_stall = 1'b1; settle();
        chk("haz_we", {15'd0, pc_we}, 16'd0);
        chk("haz_fv", {15'd0, fetch_valid}, 16'd0);

        // Wrap at 0xFFFE
        step(); br_taken = 1'b1; br_target = 16'hFFFE; settle();
        step(); settle();
        $display("wrap: pc_q=%h pc_d=%h", pc_q, pc_d);
        chk("wrap_d", pc_d, 16'h0000);
        chk("wrap_we", {15'd0, pc_we}, 16'd1);

        // HLT at 0x0020, wrong-path resolved by branch in DRAIN
        step(); br_taken = 1'b1; br_target = 16'h0020; settle();
        step(); halt_dec = 1'b1; settle();
        chk("hdec_pcq", pc_q, 16'h0020);
        chk("hdec_we", {15'd0, pc_we}, 16'd0);
        step(); settle();
        chk("drain_we", {15'd0, pc_we}, 16'd0);
        chk("drain_fv", {15'd0, fetch_valid}, 16'd0);
        step(); br_taken = 1'b1; br_target = 16'h0200; settle();
        $display("drain_br: pc_d=%h flush=%b", pc_d, if_flush);
        chk("drain_br_d", pc_d, 16'h0200);
        chk("drain_br_we", {15'd0, pc_we}, 16'd1);
        chk("drain_br_flush", {15'd0, if_flush}, 16'd1);
        step(); settle();
        chk("back_run_d", pc_d, 16'h0202);
        chk("back_run_fv", {15'd0, fetch_valid}, 16'd1);

        // HLT committed together with a branch: halt wins
        step(); halt_dec = 1'b1; settle();
        step(); settle();
        step(); settle();
        chk("drain2_we", {15'd0, pc_we}, 16'd0);
        step(); halt_commit = 1'b1; br_taken = 1'b1; br_target = 16'h0300; settle();
        chk("commit_we", {15'd0, pc_we}, 16'd0);
        chk("commit_halted", {15'd0, halted}, 16'd0);
        step(); settle();
        $display("halted: halted=%b pc_we=%b", halted, pc_we);
        chk("halted", {15'd0, halted}, 16'd1);
        step(); br_taken = 1'b1; br_target = 16'h0400; settle();
        chk("halt_br_we", {15'd0, pc_we}, 16'd0);
        chk("halt_br_flush", {15'd0, if_flush}, 16'd0);
        chk("halt_sticky", {15'd0, halted}, 16'd1);
        chk("halt_re1", {15'd0, pc_re1}, 16'd1);

        // Reset out of HALTED
        step(); rst = 1'b0; settle();
        chk("rst2_halted", {15'd0, halted}, 16'd0);
        chk("rst2_we", {15'd0, pc_we}, 16'd0);
        step(); rst = 1'b1; settle();
        chk("boot2_d", pc_d, 16'h0000);
        step(); settle();

        // Reset asserted mid-busy with a pending redirect
        step(); imem_busy = 1'b1; br_taken = 1'b1; br_target = 16'h0500; settle();
        step(); #2; rst = 1'b0; #1;
        chk("rst3_we", {15'd0, pc_we}, 16'd0);
        chk("rst3_d", pc_d, 16'h0000);
        step(); rst = 1'b1; imem_busy = 1'b0; settle();
        $display("boot3: pc_d=%h pc_we=%b", pc_d, pc_we);
        chk("boot3_we", {15'd0, pc_we}, 16'd1);
        chk("boot3_d", pc_d, 16'h0000);
        step(); settle();
        $display("post: pc_d=%h fv=%b", pc_d, fetch_valid);
        chk("nopend_d", pc_d, 16'h0002);
        chk("nopend_fv", {15'd0, fetch_valid}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
